// File: rtl/jtag_dap_sequencer.sv
// Purpose : turns one DP/AP register access into IR-write and DR-transfer commands for jtagIF,
//           caching the current IR, retrying WAIT acks and completing posted reads via DP RDBUFF.
// Ports   : req_* request/response side (debug command controller), jt_* cmd/go handshake to jtagIF,
//           wait_retries = per-transfer WAIT retry limit, ir_flush = IR cache invalidate pulse.
module jtag_dap_sequencer #(
    parameter logic [3:0] IR_DPACC    = 4'hA,
    parameter logic [3:0] IR_APACC    = 4'hB,
    parameter logic [1:0] ADDR_RDBUFF = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_go,
    input  logic        req_apndp,
    input  logic        req_rnw,
    input  logic [1:0]  req_addr32,
    input  logic [31:0] req_wdata,
    input  logic [7:0]  wait_retries,
    input  logic        ir_flush,
    output logic        req_idle,
    output logic        req_done,
    output logic [2:0]  req_ack,
    output logic [31:0] req_rdata,
    output logic [1:0]  jt_cmd,
    output logic [3:0]  jt_ir,
    output logic [1:0]  jt_addr32,
    output logic        jt_rnw,
    output logic        jt_apndp,
    output logic [31:0] jt_dwrite,
    output logic        jt_go,
    input  logic        jt_idle,
    input  logic [2:0]  jt_ack,
    input  logic [31:0] jt_dread
);

    localparam logic [2:0] ACK_OK   = 3'b010;
    localparam logic [2:0] ACK_WAIT = 3'b001;
    localparam logic [1:0] CMD_IR   = 2'd0;
    localparam logic [1:0] CMD_TFR  = 2'd1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_IR_LAUNCH,
        S_IR_WAIT,
        S_TFR_LAUNCH,
        S_TFR_WAIT,
        S_TFR_CHECK,
        S_RDB_IR_LAUNCH,
        S_RDB_IR_WAIT,
        S_RDB_LAUNCH,
        S_RDB_WAIT,
        S_RDB_CHECK,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        cap_apndp_q, cap_apndp_d;
    logic        cap_rnw_q, cap_rnw_d;
    logic [1:0]  cap_addr_q, cap_addr_d;
    logic [31:0] cap_wdata_q, cap_wdata_d;
    logic [3:0]  ir_cache_q, ir_cache_d;
    logic        ir_valid_q, ir_valid_d;
    logic [7:0]  retry_q, retry_d;
    logic [2:0]  ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]  need_ir;
    logic [3:0]  req_need_ir;

    assign need_ir     = cap_apndp_q ? IR_APACC : IR_DPACC;
    assign req_need_ir = req_apndp ? IR_APACC : IR_DPACC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cap_apndp_q <= 1'b0;
            cap_rnw_q   <= 1'b0;
            cap_addr_q  <= 2'd0;
            cap_wdata_q <= 32'd0;
            ir_cache_q  <= 4'd0;
            ir_valid_q  <= 1'b0;
            retry_q     <= 8'd0;
            ack_q       <= 3'd0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cap_apndp_q <= cap_apndp_d;
            cap_rnw_q   <= cap_rnw_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            ir_cache_q  <= ir_cache_d;
            ir_valid_q  <= ir_valid_d;
            retry_q     <= retry_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cap_apndp_d = cap_apndp_q;
        cap_rnw_d   = cap_rnw_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        ir_cache_d  = ir_cache_q;
        ir_valid_d  = ir_valid_q;
        retry_d     = retry_q;
        ack_d       = ack_q;
        rdata_d     = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_go) begin
                    cap_apndp_d = req_apndp;
                    cap_rnw_d   = req_rnw;
                    cap_addr_d  = req_addr32;
                    cap_wdata_d = req_wdata;
                    // A flush in the capture cycle forces the IR write.
                    if (!ir_flush && ir_valid_q && (ir_cache_q == req_need_ir)) begin
                        state_d = S_TFR_LAUNCH;
                    end else begin
                        state_d = S_IR_LAUNCH;
                    end
                end
            end
            S_IR_LAUNCH: if (!jt_idle) state_d = S_IR_WAIT;
            S_IR_WAIT: begin
                if (jt_idle) begin
                    ir_cache_d = need_ir;
                    ir_valid_d = 1'b1;
                    state_d    = S_TFR_LAUNCH;
                end
            end
            S_TFR_LAUNCH: if (!jt_idle) state_d = S_TFR_WAIT;
            S_TFR_WAIT:   if (jt_idle)  state_d = S_TFR_CHECK;
            S_TFR_CHECK: begin
                if (jt_ack == ACK_WAIT) begin
                    // Compare before increment, so the counter cannot wrap.
                    if (retry_q < wait_retries) begin
                        retry_d = retry_q + 8'd1;
                        state_d = S_TFR_LAUNCH;
                    end else begin
                        ack_d   = ACK_WAIT;
                        state_d = S_DONE;
                    end
                end else if (jt_ack == ACK_OK) begin
                    if (!cap_rnw_q) begin
                        ack_d   = ACK_OK;
                        state_d = S_DONE;
                    end else begin
                        // Posted read: the data arrives on the following RDBUFF transfer.
                        retry_d = 8'd0;
                        if (ir_valid_q && (ir_cache_q == IR_DPACC)) begin
                            state_d = S_RDB_LAUNCH;
                        end else begin
                            state_d = S_RDB_IR_LAUNCH;
                        end
                    end
                end else begin
                    ack_d   = jt_ack;
                    state_d = S_DONE;
                end
            end
            S_RDB_IR_LAUNCH: if (!jt_idle) state_d = S_RDB_IR_WAIT;
            S_RDB_IR_WAIT: begin
                if (jt_idle) begin
                    ir_cache_d = IR_DPACC;
                    ir_valid_d = 1'b1;
                    state_d    = S_RDB_LAUNCH;
                end
            end
            S_RDB_LAUNCH: if (!jt_idle) state_d = S_RDB_WAIT;
            S_RDB_WAIT:   if (jt_idle)  state_d = S_RDB_CHECK;
            S_RDB_CHECK: begin
                if (jt_ack == ACK_WAIT) begin
                    if (retry_q < wait_retries) begin
                        retry_d = retry_q + 8'd1;
                        state_d = S_RDB_LAUNCH;
                    end else begin
                        ack_d   = ACK_WAIT;
                        state_d = S_DONE;
                    end
                end else if (jt_ack == ACK_OK) begin
                    rdata_d = jt_dread;
                    ack_d   = ACK_OK;
                    state_d = S_DONE;
                end else begin
                    ack_d   = jt_ack;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                retry_d = 8'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush beats any same-cycle cache fill; in-flight commands continue.
        if (ir_flush) ir_valid_d = 1'b0;
    end

    // jtagIF fields decode straight from the registered state, so they are
    // constant across each LAUNCH/WAIT pair and drop to zero on reset.
    always_comb begin
        jt_cmd    = 2'd0;
        jt_ir     = 4'd0;
        jt_addr32 = 2'd0;
        jt_rnw    = 1'b0;
        jt_apndp  = 1'b0;
        jt_dwrite = 32'd0;
        jt_go     = 1'b0;
        case (state_q)
            S_IR_LAUNCH, S_IR_WAIT: begin
                jt_cmd = CMD_IR;
                jt_ir  = need_ir;
                jt_go  = (state_q == S_IR_LAUNCH);
            end
            S_TFR_LAUNCH, S_TFR_WAIT: begin
                jt_cmd    = CMD_TFR;
                jt_addr32 = cap_addr_q;
                jt_rnw    = cap_rnw_q;
                jt_apndp  = cap_apndp_q;
                jt_dwrite = cap_wdata_q;
                jt_go     = (state_q == S_TFR_LAUNCH);
            end
            S_RDB_IR_LAUNCH, S_RDB_IR_WAIT: begin
                jt_cmd = CMD_IR;
                jt_ir  = IR_DPACC;
                jt_go  = (state_q == S_RDB_IR_LAUNCH);
            end
            S_RDB_LAUNCH, S_RDB_WAIT: begin
                jt_cmd    = CMD_TFR;
                jt_addr32 = ADDR_RDBUFF;
                jt_rnw    = 1'b1;
                jt_apndp  = 1'b0;
                jt_go     = (state_q == S_RDB_LAUNCH);
            end
            default: ;
        endcase
    end

    assign req_idle  = (state_q == S_IDLE);
    assign req_done  = (state_q == S_DONE);
    assign req_ack   = ack_q;
    assign req_rdata = rdata_q;

endmodule

// File: tb/tb_jtag_dap_sequencer.sv
module tb_jtag_dap_sequencer;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [3:0]  ir;
        logic [1:0]  addr;
        logic        rnw;
        logic        apndp;
        logic [31:0] dwrite;
    } jcmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_go, req_apndp, req_rnw, ir_flush;
    logic [1:0]  req_addr32;
    logic [31:0] req_wdata;
    logic [7:0]  wait_retries;
    logic        req_idle, req_done;
    logic [2:0]  req_ack;
    logic [31:0] req_rdata;
    logic [1:0]  jt_cmd;
    logic [3:0]  jt_ir;
    logic [1:0]  jt_addr32;
    logic        jt_rnw, jt_apndp, jt_go;
    logic [31:0] jt_dwrite;
    logic        jt_idle;
    logic [2:0]  jt_ack;
    logic [31:0] jt_dread;

    int checks = 0;
    int errors = 0;

    jcmd_t      cmd_log[$];
    logic [2:0] ack_q[$];
    logic [2:0] def_ack;
    logic [31:0] rd_val;
    jcmd_t      cur;
    int         busy_cnt;
    logic [2:0] done_ack;
    logic [31:0] done_rdata;
    bit         seen;

    always #5 clk = ~clk;

    jtag_dap_sequencer dut (
        .clk(clk), .rst(rst),
        .req_go(req_go), .req_apndp(req_apndp), .req_rnw(req_rnw),
        .req_addr32(req_addr32), .req_wdata(req_wdata),
        .wait_retries(wait_retries), .ir_flush(ir_flush),
        .req_idle(req_idle), .req_done(req_done), .req_ack(req_ack), .req_rdata(req_rdata),
        .jt_cmd(jt_cmd), .jt_ir(jt_ir), .jt_addr32(jt_addr32), .jt_rnw(jt_rnw),
        .jt_apndp(jt_apndp), .jt_dwrite(jt_dwrite), .jt_go(jt_go),
        .jt_idle(jt_idle), .jt_ack(jt_ack), .jt_dread(jt_dread)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // jtagIF model: accepts go while idle, stays busy 3 cycles, then returns ack/data.
    always @(negedge clk) begin
        if (rst) begin
            jt_idle  = 1'b1;
            busy_cnt = 0;
        end else if (jt_idle) begin
            if (jt_go) begin
                cur = '{jt_cmd, jt_ir, jt_addr32, jt_rnw, jt_apndp, jt_dwrite};
                cmd_log.push_back(cur);
                jt_idle  = 1'b0;
                busy_cnt = 3;
            end
        end else begin
            chk("jt_fields_stable", {22'd0, jt_cmd, jt_ir, jt_addr32, jt_rnw, jt_apndp, jt_dwrite},
                {22'd0, cur});
            busy_cnt--;
            if (busy_cnt == 0) begin
                jt_idle = 1'b1;
                if (cur.cmd == 2'd1) begin
                    jt_ack   = (ack_q.size() > 0) ? ack_q.pop_front() : def_ack;
                    jt_dread = (cur.rnw && !cur.apndp && cur.addr == 2'd3) ? rd_val : 32'hDEAD_BEEF;
                end else begin
                    jt_ack = 3'b010;
                end
            end
        end
    end

    task automatic start_req(input logic ap, input logic rnw, input logic [1:0] addr,
                             input logic [31:0] wd, input logic flush);
        cmd_log.delete();
        req_apndp  = ap;
        req_rnw    = rnw;
        req_addr32 = addr;
        req_wdata  = wd;
        req_go     = 1'b1;
        ir_flush   = flush;
        @(negedge clk);
        req_go   = 1'b0;
        ir_flush = 1'b0;
    endtask

    task automatic do_req(input logic ap, input logic rnw, input logic [1:0] addr,
                          input logic [31:0] wd, input logic flush);
        start_req(ap, rnw, addr, wd, flush);
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            if (req_done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        done_ack   = req_ack;
        done_rdata = req_rdata;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req_go = 1'b0; req_apndp = 1'b0; req_rnw = 1'b0; ir_flush = 1'b0;
        req_addr32 = 2'd0; req_wdata = 32'd0; wait_retries = 8'd5;
        jt_idle = 1'b1; jt_ack = 3'd0; jt_dread = 32'd0;
        def_ack = 3'b010; rd_val = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_idle", {63'd0, req_idle}, 64'd1);
        chk("rst_done", {63'd0, req_done}, 64'd0);
        chk("rst_ack", {61'd0, req_ack}, 64'd0);
        chk("rst_rdata", {32'd0, req_rdata}, 64'd0);
        chk("rst_jt_go", {63'd0, jt_go}, 64'd0);
        chk("rst_jt_fields", {jt_cmd, jt_ir, jt_addr32, jt_rnw, jt_apndp, jt_dwrite}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // DP write: IR(A) then TFR.
        do_req(1'b0, 1'b0, 2'd1, 32'h5000_0000, 1'b0);
        chk("dpw_ncmd", cmd_log.size(), 2);
        chk("dpw_ir", {cmd_log[0].cmd, cmd_log[0].ir}, {2'd0, 4'hA});
        chk("dpw_tfr", {22'd0, cmd_log[1]}, {22'd0, 2'd1, 4'd0, 2'd1, 1'b0, 1'b0, 32'h5000_0000});
        chk("dpw_ack", done_ack, 3'b010);
        chk("dpw_done_pulse", {req_done, req_idle}, 2'b01);

        // AP write twice: IR(B) only on the first.
        do_req(1'b1, 1'b0, 2'd0, 32'h0000_0011, 1'b0);
        chk("apw1_ncmd", cmd_log.size(), 2);
        chk("apw1_ir", {cmd_log[0].cmd, cmd_log[0].ir}, {2'd0, 4'hB});
        chk("apw1_tfr_ap", {cmd_log[1].cmd, cmd_log[1].apndp}, {2'd1, 1'b1});
        do_req(1'b1, 1'b0, 2'd1, 32'h0000_0022, 1'b0);
        chk("apw2_ncmd", cmd_log.size(), 1);
        chk("apw2_tfr", {cmd_log[0].cmd, cmd_log[0].addr, cmd_log[0].dwrite}, {2'd1, 2'd1, 32'h22});

        // DP write switches the cache back to A.
        do_req(1'b0, 1'b0, 2'd2, 32'h1234_5678, 1'b0);
        chk("dpw2_ncmd", cmd_log.size(), 2);
        chk("dpw2_ir", cmd_log[0].ir, 4'hA);

        // AP read: IR(B), TFR read, IR(A), RDBUFF.
        rd_val = 32'h2477_0011;
        do_req(1'b1, 1'b1, 2'd3, 32'd0, 1'b0);
        chk("apr_ncmd", cmd_log.size(), 4);
        chk("apr_c0", {cmd_log[0].cmd, cmd_log[0].ir}, {2'd0, 4'hB});
        chk("apr_c1", {cmd_log[1].cmd, cmd_log[1].rnw, cmd_log[1].apndp, cmd_log[1].addr},
            {2'd1, 1'b1, 1'b1, 2'd3});
        chk("apr_c2", {cmd_log[2].cmd, cmd_log[2].ir}, {2'd0, 4'hA});
        chk("apr_c3", {cmd_log[3].cmd, cmd_log[3].rnw, cmd_log[3].apndp, cmd_log[3].addr},
            {2'd1, 1'b1, 1'b0, 2'd3});
        chk("apr_rdata", done_rdata, 32'h2477_0011);
        chk("apr_ack", done_ack, 3'b010);

        // WAIT x3 then OK with 5 retries allowed.
        wait_retries = 8'd5;
        ack_q = '{3'b001, 3'b001, 3'b001};
        do_req(1'b0, 1'b0, 2'd1, 32'hAAAA_0001, 1'b0);
        chk("wait3_ncmd", cmd_log.size(), 4);
        chk("wait3_all_tfr", {cmd_log[0].cmd, cmd_log[3].cmd}, {2'd1, 2'd1});
        chk("wait3_ack", done_ack, 3'b010);

        // WAIT forever with 2 retries.
        wait_retries = 8'd2;
        def_ack = 3'b001;
        do_req(1'b0, 1'b0, 2'd1, 32'hAAAA_0002, 1'b0);
        chk("waitinf_ncmd", cmd_log.size(), 3);
        chk("waitinf_ack", done_ack, 3'b001);

        // Zero retries: first WAIT completes.
        wait_retries = 8'd0;
        do_req(1'b0, 1'b0, 2'd1, 32'hAAAA_0003, 1'b0);
        chk("wait0_ncmd", cmd_log.size(), 1);
        chk("wait0_ack", done_ack, 3'b001);
        def_ack = 3'b010;
        wait_retries = 8'd5;

        // Fault on read TFR: no retry, no RDBUFF, rdata kept.
        ack_q = '{3'b100};
        do_req(1'b0, 1'b1, 2'd2, 32'd0, 1'b0);
        chk("fault_ncmd", cmd_log.size(), 1);
        chk("fault_ack", done_ack, 3'b100);
        chk("fault_rdata", done_rdata, 32'h2477_0011);

        // DP read with a WAIT on the RDBUFF transfer.
        rd_val = 32'hCAFE_0001;
        ack_q = '{3'b010, 3'b001};
        do_req(1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
        chk("rdbw_ncmd", cmd_log.size(), 3);
        chk("rdbw_last", {cmd_log[2].cmd, cmd_log[2].addr}, {2'd1, 2'd3});
        chk("rdbw_rdata", done_rdata, 32'hCAFE_0001);
        chk("rdbw_ack", done_ack, 3'b010);

        // Reset while the transfer is in flight.
        start_req(1'b0, 1'b0, 2'd1, 32'hBBBB_0001, 1'b0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (!jt_idle && cmd_log.size() > 0 && cmd_log[cmd_log.size() - 1].cmd == 2'd1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("midrst_reached", {63'd0, seen}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_go", {63'd0, jt_go}, 64'd0);
        chk("midrst_idle", {63'd0, req_idle}, 64'd1);
        chk("midrst_ack", {61'd0, req_ack}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        do_req(1'b0, 1'b0, 2'd1, 32'hBBBB_0002, 1'b0);
        chk("postrst_ncmd", cmd_log.size(), 2);
        chk("postrst_ir", {cmd_log[0].cmd, cmd_log[0].ir}, {2'd0, 4'hA});

        // Cache hit, then flush between writes, then flush with capture.
        do_req(1'b0, 1'b0, 2'd1, 32'hBBBB_0003, 1'b0);
        chk("hit_ncmd", cmd_log.size(), 1);
        ir_flush = 1'b1;
        @(negedge clk);
        ir_flush = 1'b0;
        do_req(1'b0, 1'b0, 2'd1, 32'hBBBB_0004, 1'b0);
        chk("flush_ncmd", cmd_log.size(), 2);
        chk("flush_ir", {cmd_log[0].cmd, cmd_log[0].ir}, {2'd0, 4'hA});
        do_req(1'b0, 1'b0, 2'd1, 32'hBBBB_0005, 1'b1);
        chk("flushcap_ncmd", cmd_log.size(), 2);
        chk("flushcap_ir", {cmd_log[0].cmd, cmd_log[0].ir}, {2'd0, 4'hA});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
